tx_queue_arbiter: RTL and testbench
===================================

# tx_queue_arbiter

Parametrised transmit-side queue arbiter for the EDM PHY buffer path: selects one of NUM_CH source FIFOs (network, request, memory, …) and drains it frame-by-frame into the XGMII TX mux. Successor to the fixed 3-queue combinational monitor. Adds:
- a registered grant FSM with frame locking;
- strict-priority or round-robin modes;
- starvation promotion;
- hysteretic pause/backpressure on a selectable channel.

## Interface
Parameters:
- NUM_CH, 4, number of source queues (2..8); index 0 is highest strict priority.
- SPACE_W, 4, width of each queue free-space count.
- SEL_W, 2, width of sel; must satisfy 2**SEL_W >= NUM_CH.
- PAUSE_CH, 0, channel whose free space drives pause.
- THRESH_LO, 3, pause asserts when space < THRESH_LO.
- THRESH_HI, 5, pause deasserts when space >= THRESH_HI (THRESH_HI > THRESH_LO).
- STARVE_MAX, 7, missed-frame count at which a waiting channel is promoted.
- RST_HOLD, 2, cycles ch_reset stays high after reset release.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- ch_empty  in  NUM_CH  per-queue empty flag.
- ch_last  in  NUM_CH  per-queue head word is last of frame.
- ch_space  in  NUM_CH*SPACE_W  per-queue free space; channel i occupies bits [i*SPACE_W +: SPACE_W].
- tx_ready  in  1  downstream accepts a word this cycle.
- rr_en  in  1  1 = round-robin, 0 = strict priority; sampled only in IDLE.
- ch_read  out  NUM_CH  one-hot read strobe (combinational from registered state).
- ch_reset  out  NUM_CH  queue reset, registered.
- sel  out  SEL_W  granted channel index; 0 when no grant.
- sel_valid  out  1  a grant is held.
- tuser  out  2  {pause, pause}; pause forces the TX MAC to IDLE.

## Operation
- States: INIT, IDLE, BUSY.
- INIT
  - Entered on reset.
  - ch_reset all ones for the duration of reset plus RST_HOLD clk cycles, then → IDLE.
  - No reads are issued in INIT.
- IDLE
  - If any channel is non-empty, the arbiter chooses a winner, registers it to grant/sel, sets sel_valid, and goes to BUSY on the next edge.
  - If all channels are empty, it stays in IDLE with sel = 0 and sel_valid = 0.
- Winner choice:
  - The lowest-index non-empty channel whose starve count equals STARVE_MAX wins first.
  - Otherwise, in strict mode, the lowest-index non-empty channel wins.
  - Otherwise, in round-robin mode, the first non-empty channel after last_grant (modulo NUM_CH) wins.
- BUSY
  - ch_read[grant] = tx_ready & ~ch_empty[grant]; all other bits are 0.
  - A read with ch_last[grant] = 1 ends the frame:
    - grant is cleared;
    - last_grant ← grant;
    - → IDLE.
  - An empty queue mid-frame holds BUSY with no read; the grant is never switched mid-frame.
- Starvation counters, one per channel, SPACE_W bits wide:
  - At each frame end, every non-empty, non-granted channel increments its counter, saturating at STARVE_MAX.
  - The granted channel's counter clears to 0 when the grant is registered.
  - rr_en changes take effect only at the next IDLE decision.
- Pause (registered, hysteretic):
  - pause ← 1 when ch_space[PAUSE_CH] < THRESH_LO.
  - pause ← 0 when ch_space[PAUSE_CH] >= THRESH_HI.
  - Otherwise pause holds its value.
  - Pause is independent of FSM state, including INIT.

## Timing
- Reset values:
  - state = INIT, ch_reset = all ones, ch_read = 0, sel = 0, sel_valid = 0.
  - tuser = 2'b00, pause = 0, last_grant = NUM_CH-1 (so channel 0 is first in round-robin), starve counters = 0.
- Grant latency: request seen in IDLE at cycle n → sel/sel_valid valid at n+1 → first ch_read possible at n+1.
- One IDLE bubble cycle between consecutive frames.
- ch_read is only ever asserted in the same cycle as tx_ready.
- tuser reacts 1 cycle after ch_space crosses a threshold.
- A single-word frame (ch_last set on the first word) occupies exactly one BUSY cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous), and the frame is abandoned; ch_reset flushes the queues.

## Test plan
- Reset: assert reset for 3 cycles, then release → ch_reset = all ones until 2 cycles after release, ch_read = 0 throughout, then IDLE with sel_valid = 0.
- Strict priority: rr_en = 0, ch1 and ch3 non-empty, 2-word frames, tx_ready = 1 → ch1 read for 2 cycles, one bubble, then ch3 read for 2 cycles; sel = 1 then 3.
- Frame lock: ch2 granted mid-frame, ch0 becomes non-empty, ch2 goes empty for 3 cycles → no read for those 3 cycles, grant stays on ch2 until ch_last, then ch0 is granted.
- Round-robin: rr_en = 1, all 4 queues continuously non-empty with 1-word frames → sel sequence 0, 1, 2, 3, 0 at 2-cycle spacing.
- Starvation: rr_en = 0, ch0 always non-empty, ch3 non-empty → after 7 ch0 frames, ch3 is granted on the 8th decision, and ch3's counter clears to 0.
- Pause hysteresis: drive ch_space[0] 6→2→4→5 → tuser = 00, then 11 one cycle after 2, stays 11 at 4, returns to 00 one cycle after 5.

Source files
------------

// File: rtl/tx_queue_arbiter.sv
// tx_queue_arbiter: transmit-side queue arbiter with frame locking, strict or
// round-robin selection, starvation promotion and hysteretic pause.
module tx_queue_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SPACE_W    = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned PAUSE_CH   = 0,
  parameter int unsigned THRESH_LO  = 3,
  parameter int unsigned THRESH_HI  = 5,
  parameter int unsigned STARVE_MAX = 7,
  parameter int unsigned RST_HOLD   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_empty,
  input  logic [NUM_CH-1:0]           ch_last,
  input  logic [NUM_CH*SPACE_W-1:0]   ch_space,
  input  logic                        tx_ready,
  input  logic                        rr_en,
  output logic [NUM_CH-1:0]           ch_read,
  output logic [NUM_CH-1:0]           ch_reset,
  output logic [SEL_W-1:0]            sel,
  output logic                        sel_valid,
  output logic [1:0]                  tuser
);

  localparam int unsigned CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [SPACE_W-1:0] STARVE_V = SPACE_W'(STARVE_MAX);
  localparam logic [SPACE_W-1:0] LO_V     = SPACE_W'(THRESH_LO);
  localparam logic [SPACE_W-1:0] HI_V     = SPACE_W'(THRESH_HI);
  localparam logic [CNT_W-1:0]   HOLD_END = CNT_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_CH-1:0]     r_ch_reset;
  logic [CNT_W-1:0]      r_rst_cnt;
  logic [SEL_W-1:0]      r_grant;
  logic                  r_sel_valid;
  logic [SEL_W-1:0]      r_last;
  logic [SPACE_W-1:0]    r_starve [NUM_CH];
  logic                  r_pause;

  logic [SPACE_W-1:0]    w_space;
  logic                  w_any_req;
  logic                  w_read;
  logic                  w_frame_end;
  logic                  w_starve_hit;
  logic [SEL_W-1:0]      w_starve_win;
  logic [SEL_W-1:0]      w_strict_win;
  logic [SEL_W-1:0]      w_rr_win;
  logic [SEL_W-1:0]      w_win;
  logic                  w_unused_space;

  assign w_space        = ch_space[PAUSE_CH*SPACE_W +: SPACE_W];
  assign w_unused_space = ^ch_space;
  assign w_any_req      = ~&ch_empty;

  // Read strobe: only the locked channel, only when downstream takes a word
  assign w_read      = (r_state == S_BUSY) && tx_ready && !ch_empty[r_grant];
  assign w_frame_end = w_read && ch_last[r_grant];
  assign ch_read     = w_read ? (NUM_CH'(1) << r_grant) : '0;

  assign ch_reset  = r_ch_reset;
  assign sel       = r_grant;
  assign sel_valid = r_sel_valid;
  assign tuser     = {r_pause, r_pause};

  // Winner selection: starved channel first, else strict or round-robin
  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_win = '0;
    w_strict_win = '0;
    w_rr_win     = '0;
    // descending scan so the lowest index is the last one written
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (!ch_empty[i]) begin
        w_strict_win = SEL_W'(i);
        if (r_starve[i] == STARVE_V) begin
          w_starve_hit = 1'b1;
          w_starve_win = SEL_W'(i);
        end
      end
    end
    // wrap-around candidates first, then overridden by any channel after last_grant
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (!ch_empty[i] && (SEL_W'(i) <= r_last)) w_rr_win = SEL_W'(i);
    end
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (!ch_empty[i] && (SEL_W'(i) > r_last)) w_rr_win = SEL_W'(i);
    end
    w_win = w_starve_hit ? w_starve_win : (rr_en ? w_rr_win : w_strict_win);
  end

  // Grant FSM: reset hold, idle decision, frame-locked drain, starvation tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_ch_reset  <= '1;
      r_rst_cnt   <= '0;
      r_grant     <= '0;
      r_sel_valid <= 1'b0;
      r_last      <= SEL_W'(NUM_CH - 1);
      for (int i = 0; i < int'(NUM_CH); i++) r_starve[i] <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_rst_cnt == HOLD_END) begin
            r_ch_reset <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (w_any_req) begin
            r_grant          <= w_win;
            r_sel_valid      <= 1'b1;
            r_starve[w_win]  <= '0;
            r_state          <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_frame_end) begin
            r_grant     <= '0;
            r_sel_valid <= 1'b0;
            r_last      <= r_grant;
            r_state     <= S_IDLE;
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if ((SEL_W'(i) != r_grant) && !ch_empty[i] && (r_starve[i] != STARVE_V))
                r_starve[i] <= r_starve[i] + SPACE_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Hysteretic pause on the monitored channel's free space, independent of FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pause <= 1'b0;
    end else if (w_space < LO_V) begin
      r_pause <= 1'b1;
    end else if (w_space >= HI_V) begin
      r_pause <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_queue_arbiter.sv
// Directed bench for tx_queue_arbiter with default parameters.
module tb_tx_queue_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  ch_empty;
  logic [3:0]  ch_last;
  logic [15:0] ch_space;
  logic        tx_ready;
  logic        rr_en;
  logic [3:0]  ch_read;
  logic [3:0]  ch_reset;
  logic [1:0]  sel;
  logic        sel_valid;
  logic [1:0]  tuser;

  int n_pass;
  int n_total;

  tx_queue_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .ch_empty (ch_empty),
    .ch_last  (ch_last),
    .ch_space (ch_space),
    .tx_ready (tx_ready),
    .rr_en    (rr_en),
    .ch_read  (ch_read),
    .ch_reset (ch_reset),
    .sel      (sel),
    .sel_valid(sel_valid),
    .tuser    (tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_chk(input string tag, input logic [1:0] s, input logic [3:0] rd);
    check({tag, "_sel"}, 32'(sel), 32'(s));
    check({tag, "_valid"}, 32'(sel_valid), 32'd1);
    check({tag, "_read"}, 32'(ch_read), 32'(rd));
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_valid"}, 32'(sel_valid), 32'd0);
    check({tag, "_read"}, 32'(ch_read), 32'd0);
  endtask

  initial begin
    logic [1:0] rr_exp;
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    ch_empty = 4'b1111;
    ch_last = 4'b0000;
    ch_space = 16'h8888;
    tx_ready = 1'b1;
    rr_en = 1'b0;

    // reset held for three edges
    #1;
    check("rst_ch_reset", 32'(ch_reset), 32'hF);
    idle_chk("rst");
    check("rst_tuser", 32'(tuser), 32'd0);
    tick(); tick(); tick();
    check("rst_hold_ch_reset", 32'(ch_reset), 32'hF);
    reset = 1'b0;
    tick();
    check("init1_ch_reset", 32'(ch_reset), 32'hF);
    check("init1_read", 32'(ch_read), 32'd0);
    tick();
    check("init2_ch_reset", 32'(ch_reset), 32'h0);
    idle_chk("init2");

    // strict priority: ch1 then ch3, 2-word frames
    ch_empty = 4'b0101;
    tick();
    grant_chk("strict_c1w1", 2'd1, 4'b0010);
    tick();
    grant_chk("strict_c1w2", 2'd1, 4'b0010);
    ch_last = 4'b0010;
    tick();
    idle_chk("strict_bubble");
    ch_empty = 4'b0111;
    ch_last = 4'b0000;
    tick();
    grant_chk("strict_c3w1", 2'd3, 4'b1000);
    tick();
    grant_chk("strict_c3w2", 2'd3, 4'b1000);
    ch_last = 4'b1000;
    tick();
    idle_chk("strict_end");

    // frame lock: ch2 starved of data mid-frame while ch0 waits
    ch_empty = 4'b1011;
    ch_last = 4'b0000;
    tick();
    grant_chk("lock_c2w1", 2'd2, 4'b0100);
    ch_empty = 4'b1110;
    tick();
    grant_chk("lock_gap1", 2'd2, 4'b0000);
    tick();
    grant_chk("lock_gap2", 2'd2, 4'b0000);
    tick();
    grant_chk("lock_gap3", 2'd2, 4'b0000);
    ch_empty = 4'b1010;
    ch_last = 4'b0100;
    tick();
    idle_chk("lock_end");
    ch_empty = 4'b1110;
    ch_last = 4'b0001;
    tick();
    grant_chk("lock_c0", 2'd0, 4'b0001);
    tx_ready = 1'b0;
    tick();
    grant_chk("noready_hold", 2'd0, 4'b0000);
    tx_ready = 1'b1;
    tick();
    idle_chk("noready_end");

    // round-robin, last grant was ch0 so rotation starts at ch1
    rr_en = 1'b1;
    ch_empty = 4'b0000;
    ch_last = 4'b1111;
    rr_exp = 2'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      grant_chk($sformatf("rr%0d", k), rr_exp, 4'b0001 << rr_exp);
      tick();
      idle_chk($sformatf("rr%0d_bubble", k));
      rr_exp = rr_exp + 2'd1;
    end

    // asynchronous reset in the middle of a frame
    ch_last = 4'b0000;
    tick();
    grant_chk("midrst_pre", 2'd2, 4'b0100);
    #2;
    reset = 1'b1;
    #1;
    idle_chk("midrst");
    check("midrst_ch_reset", 32'(ch_reset), 32'hF);
    ch_empty = 4'b1111;
    rr_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst2_init_ch_reset", 32'(ch_reset), 32'hF);
    tick();
    check("rst2_idle_ch_reset", 32'(ch_reset), 32'h0);

    // starvation: ch0 hogs in strict mode, ch3 promoted on the 8th decision
    ch_empty = 4'b0110;
    ch_last = 4'b1001;
    for (int k = 0; k < 7; k++) begin
      tick();
      grant_chk($sformatf("starve_c0_%0d", k), 2'd0, 4'b0001);
      tick();
    end
    tick();
    grant_chk("starve_c3", 2'd3, 4'b1000);
    tick();
    idle_chk("starve_c3_end");
    tick();
    grant_chk("starve_cleared", 2'd0, 4'b0001);

    // pause hysteresis on ch0 free space
    check("pause_init", 32'(tuser), 32'd0);
    ch_space[3:0] = 4'd6;
    tick();
    check("pause_6", 32'(tuser), 32'd0);
    ch_space[3:0] = 4'd2;
    #1;
    check("pause_2_same_cycle", 32'(tuser), 32'd0);
    tick();
    check("pause_2", 32'(tuser), 32'd3);
    ch_space[3:0] = 4'd4;
    tick();
    check("pause_4_hold", 32'(tuser), 32'd3);
    ch_space[3:0] = 4'd5;
    #1;
    check("pause_5_same_cycle", 32'(tuser), 32'd3);
    tick();
    check("pause_5", 32'(tuser), 32'd0);
    ch_space[3:0] = 4'd3;
    tick();
    check("pause_3_hold", 32'(tuser), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
